// File: rtl/second_barrel_shifter.sv
// Registered barrel rotator: rotates a WIDTH-bit word right or left by 0..WIDTH-1
// positions, one result per valid input, one cycle of latency.
module second_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [AMT_W-1:0] amt_in,
    input  logic             sel_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out_out,
    output logic             valid_out
);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    // Right rotate by a fixed, non-zero power-of-two distance below WIDTH.
    function automatic logic [WIDTH-1:0] rotr_pow2(input logic [WIDTH-1:0] x, input int sh);
        return (x >> sh) | (x << (WIDTH - sh));
    endfunction

    logic [WIDTH-1:0] rot_d;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    // Left rotate is done as reverse -> rotate right -> reverse, sharing one rotator.
    always_comb begin
        logic [WIDTH-1:0] v;
        v = sel_in ? bit_rev(a_in) : a_in;
        for (int s = 0; s < AMT_W; s++) begin
            if (amt_in[s]) begin
                v = rotr_pow2(v, 1 << s);
            end
        end
        rot_d = sel_in ? bit_rev(v) : v;
    end

    always_comb begin
        out_d   = valid_in ? rot_d : out_q;
        valid_d = valid_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_out   = out_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_second_barrel_shifter.sv
// Scoreboard bench for second_barrel_shifter: driver queues expected rotates,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_second_barrel_shifter;

    logic       clk_in;
    logic       rst_n_in;
    logic [7:0] a_in;
    logic [2:0] amt_in;
    logic       sel_in;
    logic       valid_in;
    logic [7:0] out_out;
    logic       valid_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'h00;

    second_barrel_shifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .a_in      (a_in),
        .amt_in    (amt_in),
        .sel_in    (sel_in),
        .valid_in  (valid_in),
        .out_out   (out_out),
        .valid_out (valid_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Reference: bit i of the result comes from bit (i +/- amt) mod 8 of the input.
    function automatic logic [7:0] rot_model(input logic [7:0] a, input int amt, input logic sel);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx  = sel ? ((i - amt + 8) % 8) : ((i + amt) % 8);
            r[i] = a[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called just after a rising edge; the item is captured on the next edge.
    task automatic send(input logic [7:0] a, input logic [2:0] amt, input logic sel,
                        input logic [7:0] exp);
        a_in     = a;
        amt_in   = amt;
        sel_in   = sel;
        valid_in = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            a_in     = 8'($urandom);
            amt_in   = 3'($urandom);
            sel_in   = 1'($urandom);
            @(posedge clk_in);
            #1;
        end
    endtask

    // Monitor
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1) begin
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got out=%h with no pending result", out_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rotate", out_out, e);
                    last_exp = e;
                end
            end else begin
                check("hold", out_out, last_exp);
            end
        end
    end

    initial begin
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        a_in     = 8'h00;
        amt_in   = 3'd0;
        sel_in   = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_out", out_out, 8'h00);
        check("reset_valid", {7'd0, valid_out}, 8'h00);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Directed cases
        send(8'b0000_1111, 3'd2, 1'b0, 8'b1100_0011);
        send(8'b0000_1111, 3'd2, 1'b1, 8'b0011_1100);
        send(8'h81, 3'd0, 1'b0, 8'h81);
        send(8'h81, 3'd0, 1'b1, 8'h81);
        send(8'h81, 3'd7, 1'b0, 8'h03);
        send(8'h81, 3'd7, 1'b1, 8'hC0);
        send(8'b0000_1111, 3'd2, 1'b0, 8'b1100_0011);
        idle(3);

        // Mid-run asynchronous reset drops the pending result
        send(8'h5A, 3'd3, 1'b1, rot_model(8'h5A, 3, 1'b1));
        valid_in = 1'b0;
        #1;
        rst_n_in = 1'b0;
        #1;
        check("async_reset_out", out_out, 8'h00);
        check("async_reset_valid", {7'd0, valid_out}, 8'h00);
        exp_q.delete();
        last_exp = 8'h00;
        @(posedge clk_in);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        send(8'h96, 3'd5, 1'b0, rot_model(8'h96, 5, 1'b0));
        idle(2);

        // Exhaustive back-to-back sweep
        for (int a = 0; a < 256; a++) begin
            for (int amt = 0; amt < 8; amt++) begin
                for (int s = 0; s < 2; s++) begin
                    send(8'(a), 3'(amt), 1'(s), rot_model(8'(a), amt, 1'(s)));
                end
            end
        end
        idle(2);

        // Random stimulus with random gaps
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            logic [2:0] amt;
            logic       s;
            a   = 8'($urandom);
            amt = 3'($urandom);
            s   = 1'($urandom);
            send(a, amt, s, rot_model(a, int'(amt), s));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
